// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forwarding-select codes, register address width and the register match rule.
package hazard_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Two register numbers refer to the same live value. With r0_zero set,
    // register 0 is hard-wired and never carries a dependency.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] a,
                                       input logic [REG_ADDR_W-1:0] b,
                                       input logic                  r0_zero);
        return (a == b) && !(r0_zero && (a == '0));
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding comparator. The EX/MEM result is
// younger than the MEM/WB result, so it takes precedence.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int R0_ZERO = 1
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic R0 = (R0_ZERO != 0);

    // Pick the youngest in-flight producer for each EX source operand.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_regwrite && reg_match(mem_rd, ex_rs1, R0)) fwd_a = FWD_MEM;
        else if (wb_regwrite && reg_match(wb_rd, ex_rs1, R0)) fwd_a = FWD_WB;
        if (mem_regwrite && reg_match(mem_rd, ex_rs2, R0)) fwd_b = FWD_MEM;
        else if (wb_regwrite && reg_match(wb_rd, ex_rs2, R0)) fwd_b = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage 16-bit core: load-use
// stalls, taken-branch squash, data-memory wait stalls with a timeout
// watchdog, and ALU forwarding selects. State updates on the falling clock
// edge together with the pipeline registers.
// Optional: define HAZARD_PERF_CNT_EN to add three saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int R0_ZERO         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  exmem_stall,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0]           lu_stall_cnt,
    output logic [15:0]           br_flush_cnt,
    output logic [15:0]           mem_wait_cnt,
`endif
    output state_t                dbg_state
);

    localparam logic R0 = (R0_ZERO != 0);

    // Memory handshake: mem_req marks an active MEM-stage access; the access
    // completes in the cycle where mem_req (or an already-pending wait) sees
    // mem_ready = 1. While mem_ready stays low the pipeline is frozen.

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  brcnt, brcnt_n;
    logic [1:0]  fwd_a_raw, fwd_b_raw;
    logic        mem_wait_req;
    logic        load_use;

    assign mem_wait_req = mem_req && !mem_ready;
    assign load_use     = ex_memread && ex_regwrite &&
                          ((id_use_rs1 && reg_match(ex_rd, id_rs1, R0)) ||
                           (id_use_rs2 && reg_match(ex_rd, id_rs2, R0)));
    assign dbg_state    = state;

    fwd_unit #(.R0_ZERO(R0_ZERO)) u_fwd (
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    // Forwarding is suppressed in reset and once the controller has failed.
    assign fwd_a = (rst || state == ERR) ? FWD_RF : fwd_a_raw;
    assign fwd_b = (rst || state == ERR) ? FWD_RF : fwd_b_raw;

    // State, wait counter and branch-flush counter registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            brcnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            brcnt <= brcnt_n;
        end
    end

    // Next-state and stall/flush decode; a memory wait beats a branch, which beats load-use.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        brcnt_n     = brcnt;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        err         = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait_req) begin
                    {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
                    memwb_flush = 1'b1;
                    state_n     = MEM_WAIT;
                    cnt_n       = 16'd1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_n = BR_FLUSH;
                        brcnt_n = 3'(BR_FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            BR_FLUSH: begin
                if (mem_wait_req) begin
                    {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
                    memwb_flush = 1'b1;
                    state_n     = MEM_WAIT;
                    cnt_n       = 16'd1;
                    brcnt_n     = '0;
                end else begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (brcnt <= 3'd1) begin
                        state_n = RUN;
                        brcnt_n = '0;
                    end else begin
                        brcnt_n = brcnt - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
                    memwb_flush = 1'b1;
                    if (cnt >= 16'(MEM_TIMEOUT)) state_n = ERR;
                    if (cnt != 16'hFFFF) cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
                err = 1'b1;
            end
        endcase
        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            idex_stall  = 1'b0;
            exmem_stall = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            memwb_flush = 1'b0;
            err         = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters: load-use is the only case stalling PC without EX/MEM,
    // IF/ID flush only comes from branches, MEM/WB flush only from memory waits.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            br_flush_cnt <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (pc_stall && !exmem_stall && lu_stall_cnt != 16'hFFFF)
                lu_stall_cnt <= lu_stall_cnt + 16'd1;
            if (ifid_flush && br_flush_cnt != 16'hFFFF)
                br_flush_cnt <= br_flush_cnt + 16'd1;
            if (memwb_flush && mem_wait_cnt != 16'hFFFF)
                mem_wait_cnt <= mem_wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written multi-cycle
// sequences (timeout, asynchronous reset abort) and randomized traffic
// checked against a behavioural model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int BR_N = 2;
    localparam int TO   = 8;

    typedef struct packed {
        logic [2:0] id_rs1;
        logic [2:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic [2:0] ex_rs1;
        logic [2:0] ex_rs2;
        logic [2:0] ex_rd;
        logic       ex_memread;
        logic       ex_regwrite;
        logic [2:0] mem_rd;
        logic       mem_regwrite;
        logic [2:0] wb_rd;
        logic       wb_regwrite;
        logic       branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic [11:0] exp;
    } vec_t;

    // Expected output word: {pc, ifid, idex, exmem stalls, ifid/idex/memwb flush, fwd_a, fwd_b, err}
    localparam logic [11:0] E_NONE = 12'b0000_000_00_00_0;
    localparam logic [11:0] E_LU   = 12'b1100_010_00_00_0;
    localparam logic [11:0] E_BR   = 12'b0000_110_00_00_0;
    localparam logic [11:0] E_MW   = 12'b1111_001_00_00_0;
    localparam logic [11:0] E_ERR  = 12'b1111_000_00_00_1;

    logic clk, rst;
    logic [2:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, mem_regwrite, wb_regwrite;
    logic branch_taken, mem_req, mem_ready;
    logic pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic ifid_flush, idex_flush, memwb_flush, err;
    logic [1:0] fwd_a, fwd_b;
    state_t dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif
    logic [11:0] dut_out;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: remaining extra flush cycles, elapsed wait cycles, failure flag.
    int m_br   = 0;
    int m_wait = 0;
    bit m_err  = 0;

    vec_t tab[$];

    hazard_ctrl #(.BR_FLUSH_CYCLES(BR_N), .MEM_TIMEOUT(TO), .R0_ZERO(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idex_stall   (idex_stall),
        .exmem_stall  (exmem_stall),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_flush  (memwb_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .err          (err),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt (lu_stall_cnt),
        .br_flush_cnt (br_flush_cnt),
        .mem_wait_cnt (mem_wait_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    assign dut_out = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                      ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, err};

    // Clock: state in the DUT moves on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input in_t v);
        id_rs1       = v.id_rs1;
        id_rs2       = v.id_rs2;
        id_use_rs1   = v.id_use_rs1;
        id_use_rs2   = v.id_use_rs2;
        ex_rs1       = v.ex_rs1;
        ex_rs2       = v.ex_rs2;
        ex_rd        = v.ex_rd;
        ex_memread   = v.ex_memread;
        ex_regwrite  = v.ex_regwrite;
        mem_rd       = v.mem_rd;
        mem_regwrite = v.mem_regwrite;
        wb_rd        = v.wb_rd;
        wb_regwrite  = v.wb_regwrite;
        branch_taken = v.branch_taken;
        mem_req      = v.mem_req;
        mem_ready    = v.mem_ready;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        n_checks++;
        if (dut_out !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, dut_out, exp);
        end
    endtask

    task automatic check_state(input string name, input state_t exp);
        n_checks++;
        if (dbg_state !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: state got %0d expected %0d", name, $time, dbg_state, exp);
        end
    endtask

    // One cycle: drive after the rising edge, check well before the falling edge.
    task automatic apply(input in_t v, input logic [11:0] exp, input string name);
        @(posedge clk);
        drive(v);
        #1;
        check(name, exp);
    endtask

    task automatic add(input in_t v, input logic [11:0] exp);
        vec_t t;
        t.i   = v;
        t.exp = exp;
        tab.push_back(t);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [2:0] rs, input in_t v);
        if (rs != 0 && v.mem_regwrite && v.mem_rd == rs) return 2'b10;
        if (rs != 0 && v.wb_regwrite && v.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lu_ref(input in_t v);
        return v.ex_memread && v.ex_regwrite && v.ex_rd != 0 &&
               ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) ||
                (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
    endfunction

    // Reference: outputs for this cycle, then advance the model to the next cycle.
    task automatic model_eval(input in_t v, input logic r, output logic [11:0] e);
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa, fb;
        logic       er;
        st = '0;
        fl = '0;
        er = 1'b0;
        fa = fwd_ref(v.ex_rs1, v);
        fb = fwd_ref(v.ex_rs2, v);
        if (r) begin
            m_br = 0; m_wait = 0; m_err = 0;
            fa = '0; fb = '0;
        end else if (m_err) begin
            st = 4'hF; er = 1'b1; fa = '0; fb = '0;
        end else if (m_wait > 0) begin
            if (v.mem_ready) m_wait = 0;
            else begin
                st = 4'hF; fl = 3'b001;
                if (m_wait >= TO) begin m_err = 1; m_wait = 0; end
                else m_wait++;
            end
        end else if (v.mem_req && !v.mem_ready) begin
            st = 4'hF; fl = 3'b001; m_wait = 1; m_br = 0;
        end else if (m_br > 0) begin
            fl = 3'b110; m_br--;
        end else if (v.branch_taken) begin
            fl = 3'b110; m_br = BR_N - 1;
        end else if (lu_ref(v)) begin
            st = 4'b1100; fl = 3'b010;
        end
        e = {st, fl, fa, fb, er};
    endtask

    initial begin
        in_t v, v_lu;
        logic [11:0] e;
        logic r;

        // Reset: outputs must stay quiet even with hazard-causing inputs present.
        v_lu = '0;
        v_lu.ex_memread = 1; v_lu.ex_regwrite = 1; v_lu.ex_rd = 3;
        v_lu.id_rs1 = 3; v_lu.id_use_rs1 = 1;
        rst = 1'b1;
        v = v_lu; v.branch_taken = 1;
        drive(v);
        @(posedge clk); #1;
        check("reset_outputs", E_NONE);
        check_state("reset_state", RUN);
        @(posedge clk);
        drive('0);
        rst = 1'b0;

        // Directed table, applied back-to-back from RUN.
        add('0, E_NONE);
        add(v_lu, E_LU);
        add('0, E_NONE);
        v = v_lu; v.ex_rd = 0; v.id_rs1 = 0; add(v, E_NONE);
        v = v_lu; v.id_use_rs1 = 0; add(v, E_NONE);
        v = '0; v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 4; v.id_rs2 = 4; v.id_use_rs2 = 1;
        add(v, E_LU);
        v = '0; v.branch_taken = 1; add(v, E_BR);
        add('0, E_BR);
        add('0, E_NONE);
        v = '0; v.mem_req = 1; add(v, E_MW);
        add(v, E_MW);
        v.branch_taken = 1; add(v, E_MW);
        v.branch_taken = 0; add(v, E_MW);
        v.mem_ready = 1; v.branch_taken = 1; add(v, E_NONE);
        v = '0; v.branch_taken = 1; add(v, E_BR);
        add('0, E_BR);
        add('0, E_NONE);
        v = '0; v.mem_rd = 5; v.wb_rd = 5; v.mem_regwrite = 1; v.wb_regwrite = 1;
        v.ex_rs1 = 5; v.ex_rs2 = 2; add(v, {7'b0, 2'b10, 2'b00, 1'b0});
        v.mem_regwrite = 0; add(v, {7'b0, 2'b01, 2'b00, 1'b0});
        v = '0; v.ex_rs1 = 0; v.ex_rs2 = 5; v.mem_rd = 5; v.wb_rd = 0;
        v.mem_regwrite = 1; v.wb_regwrite = 1; add(v, {7'b0, 2'b00, 2'b10, 1'b0});
        v = v_lu; v.branch_taken = 1; v.mem_req = 1; add(v, E_MW);
        v = '0; v.mem_req = 1; v.mem_ready = 1; add(v, E_NONE);
        add('0, E_NONE);
        v = '0; v.branch_taken = 1; add(v, E_BR);
        v = '0; v.mem_req = 1; add(v, E_MW);
        v.mem_ready = 1; add(v, E_NONE);
        add('0, E_NONE);

        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k].i, tab[k].exp, $sformatf("table[%0d]", k));
        end

        // Timeout: the RUN cycle plus TO wait cycles stall without err, then ERR.
        v = '0; v.mem_req = 1;
        apply(v, E_MW, "to_enter");
        for (int k = 1; k <= TO; k++) apply(v, E_MW, $sformatf("to_wait%0d", k));
        v.mem_ready = 1; v.branch_taken = 1; v.ex_rs1 = 5; v.mem_rd = 5; v.mem_regwrite = 1;
        for (int k = 0; k < 3; k++) apply(v, E_ERR, "err_sticky");
        check_state("err_state", ERR);

        // Asynchronous reset mid-cycle clears ERR immediately.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("err_rst_async", E_NONE);
        check_state("err_rst_state", RUN);
        @(posedge clk);
        drive('0);
        rst = 1'b0;
        apply('0, E_NONE, "after_rst");

        // Reset asserted during BR_FLUSH aborts the flush at once.
        v = '0; v.branch_taken = 1;
        apply(v, E_BR, "br_start");
        @(posedge clk);
        drive('0);
        #1;
        check_state("br_flush_state", BR_FLUSH);
        rst = 1'b1;
        #1;
        check("br_rst_async", E_NONE);
        check_state("br_rst_state", RUN);
        @(posedge clk);
        rst = 1'b0;

        // Randomized traffic against the behavioural model.
        m_br = 0; m_wait = 0; m_err = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            v.id_rs1       = 3'($urandom_range(0, 3));
            v.id_rs2       = 3'($urandom_range(0, 3));
            v.id_use_rs1   = 1'($urandom_range(0, 1));
            v.id_use_rs2   = 1'($urandom_range(0, 1));
            v.ex_rs1       = 3'($urandom_range(0, 3));
            v.ex_rs2       = 3'($urandom_range(0, 3));
            v.ex_rd        = 3'($urandom_range(0, 3));
            v.ex_memread   = 1'($urandom_range(0, 1));
            v.ex_regwrite  = 1'($urandom_range(0, 1));
            v.mem_rd       = 3'($urandom_range(0, 3));
            v.mem_regwrite = 1'($urandom_range(0, 1));
            v.wb_rd        = 3'($urandom_range(0, 3));
            v.wb_regwrite  = 1'($urandom_range(0, 1));
            v.branch_taken = ($urandom_range(0, 5) == 0);
            v.mem_req      = ($urandom_range(0, 3) == 0);
            v.mem_ready    = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 63) == 0);
            rst = r;
            drive(v);
            #1;
            model_eval(v, r, e);
            check("random", e);
        end
        @(posedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
